icache: RTL



---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/icache.sv | 73 +++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split and frame layout.
package cpu_types_pkg;
    localparam int IIDX_W   = 4;
    localparam int ITAG_W   = 30 - IIDX_W;
    localparam int IFRAMES  = 1 << IIDX_W;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;
endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache with zero-latency hits and a
// single outstanding miss fill from the memory controller.
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state_q, state_d;
    icache_frame_t frames_q [IFRAMES];
    icache_frame_t frame_rd;
    icachef_t      addr_f;
    logic          hit;
    logic          fill;

    assign addr_f   = icachef_t'(imemaddr);
    assign frame_rd = frames_q[addr_f.idx];
    assign hit      = imemREN & frame_rd.valid & (frame_rd.tag == addr_f.tag) & (state_q == IDLE);
    assign ihit     = hit;
    assign imemload = hit ? frame_rd.data : 32'h0;

    always_comb begin
        state_d = state_q;
        fill    = 1'b0;
        iREN    = 1'b0;
        iaddr   = 32'h0;
        case (state_q)
            IDLE: begin
                if (imemREN && !hit)
                    state_d = FETCH;
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {imemaddr[31:2], 2'b00};
                // Dropping the request abandons the fill even if data arrives now.
                if (!imemREN) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Only the valid bits are cleared; tag/data stay as storage without reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < IFRAMES; i++)
                frames_q[i].valid <= 1'b0;
        end else if (fill) begin
            frames_q[addr_f.idx] <= '{valid: 1'b1, tag: addr_f.tag, data: iload};
        end
    end
endmodule
